// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts W-bit parallel words through a one-deep holding
// register and sends them out LSB first for a downstream right-shift register.
// While one word is shifting, the next word can wait in the holding register.
// When it is there, the two words go out with no gap between them.
module serial_word_feeder #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         clrb,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         sdr_out,
   output logic         sd_valid,
   output logic         word_done
);

   localparam int unsigned   CW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [W-1:0]    shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept;

   // Outputs decode registered state only.
   // Reset forces them low without waiting for a clock edge.
   always_comb begin
      din_ready = ~hold_full_q & clrb;
      sd_valid  = (state_q == SHIFT);
      sdr_out   = sd_valid & shift_q[0];
      word_done = sd_valid && (cnt_q == LAST);
   end

   // Next-state logic for the FSM, holding register, shifter and bit counter.
   // A word can be accepted only when hold_full is 0.
   // A word can be transferred to the shifter only when hold_full is 1.
   // So acceptance and transfer never happen on the same edge.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      accept      = din_valid & din_ready;

      unique case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST) begin
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q + CW'(1);
            end else if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         hold_d      = din;
         hold_full_d = 1'b1;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clrb) begin
      if (!clrb) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder. The W=4 instance uses a scoreboard.
// The stimulus side queues the expected bits and words.
// A monitor on the falling edge takes them off the queues and compares.
// The W=8 instance is checked directly against a table worked out by hand.
module tb_serial_word_feeder;

   logic       clk = 1'b0;
   logic       clrb;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready, sdr_out, sd_valid, word_done;

   logic [7:0] din8;
   logic       din_valid8;
   logic       din_ready8, sdr_out8, sd_valid8, word_done8;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [1:0]  bitq[$];
   logic [3:0]  wordq[$];
   logic [3:0]  ds;
   logic        pend = 1'b0;
   logic [3:0]  pend_word = '0;
   logic [31:0] cap = '0;
   int unsigned cap_n = 0, done_n = 0, run = 0, max_run = 0;

   serial_word_feeder #(.W(4)) dut (
      .clk(clk), .clrb(clrb), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .sdr_out(sdr_out), .sd_valid(sd_valid),
      .word_done(word_done)
   );

   serial_word_feeder #(.W(8)) dut8 (
      .clk(clk), .clrb(clrb), .din(din8), .din_valid(din_valid8),
      .din_ready(din_ready8), .sdr_out(sdr_out8), .sd_valid(sd_valid8),
      .word_done(word_done8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream right-shift register fed from the serial output.
   always @(posedge clk or negedge clrb) begin
      if (!clrb) ds <= '0;
      else if (sd_valid) ds <= {sdr_out, ds[3:1]};
   end

   // Monitor: compares the DUT outputs against the scoreboard queues.
   always @(negedge clk) begin : mon
      logic [1:0] e;
      if (clrb === 1'b0) begin
         chk("rst_outputs", {sd_valid, sdr_out, word_done, din_ready}, 4'b0000);
         run = 0;
      end else if (clrb === 1'b1) begin
         if (pend) begin
            chk("ds_word", ds, pend_word);
            pend = 1'b0;
         end
         if (sd_valid) begin
            run++;
            if (run > max_run) max_run = run;
            cap = {cap[30:0], sdr_out};
            cap_n++;
            if (bitq.size() == 0) begin
               chk("unexpected_bit", 1, 0);
            end else begin
               e = bitq.pop_front();
               chk("sdr_out", sdr_out, e[0]);
               chk("word_done", word_done, e[1]);
            end
            if (word_done) begin
               done_n++;
               if (wordq.size() == 0) chk("unexpected_word", 1, 0);
               else begin
                  pend_word = wordq.pop_front();
                  pend      = 1'b1;
               end
            end
         end else begin
            run = 0;
            chk("idle_outputs", {sdr_out, word_done}, 2'b00);
         end
      end
   end

   // Offer a word; show changing junk on din until the DUT can take it.
   task automatic send(input logic [3:0] w);
      int unsigned t = 0;
      din_valid = 1'b1;
      while (!din_ready && t < 40) begin
         din = t[0] ? ~w : (~w ^ 4'h5);
         @(posedge clk); #1;
         t++;
      end
      chk("send_timeout", (t < 40), 1);
      if (t < 40) begin
         din = w;
         for (int i = 0; i < 4; i++) bitq.push_back({(i == 3), w[i]});
         wordq.push_back(w);
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      din       = '0;
   endtask

   task automatic wait_drain();
      int unsigned t = 0;
      while ((bitq.size() != 0 || sd_valid) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_timeout", (t < 100), 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic clear_stats();
      cap = '0; cap_n = 0; done_n = 0; max_run = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [3:0] v1011;
      int         bits8 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      v1011 = 4'b1011;

      // Reset with din_valid high: nothing is accepted.
      clrb = 1'b0; din = 4'hF; din_valid = 1'b1;
      din8 = '0; din_valid8 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_ready", din_ready, 0);
      @(negedge clk); #1;
      din_valid = 1'b0;
      clrb = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", din_ready, 1);
      chk("rel_idle", sd_valid, 0);
      repeat (3) begin @(posedge clk); #1; chk("no_accept", sd_valid, 0); end

      // Single word, with the latency checked cycle by cycle.
      send(v1011);
      chk("lat_k", sd_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("single_valid", sd_valid, 1);
         chk("single_bit", sdr_out, v1011[i]);
         chk("single_done", word_done, (i == 3));
      end
      @(posedge clk); #1;
      chk("single_idle", sd_valid, 0);
      wait_drain();

      // Back-to-back words, with no gap expected between them.
      clear_stats();
      send(4'b0110);
      send(4'b1001);
      chk("held_ready", din_ready, 0);
      wait_drain();
      chk("b2b_bits", cap[7:0], 8'b0110_1001);
      chk("b2b_count", cap_n, 8);
      chk("b2b_done", done_n, 2);
      chk("b2b_run", max_run, 8);

      // Backpressure: din changes on edges where the word is not accepted.
      send(4'b0011);
      send(4'b1100);
      send(4'b0101);
      wait_drain();

      // Reset in the middle of a word, while another word is held.
      send(4'b1111);
      send(4'b0001);
      @(posedge clk); #1;
      @(negedge clk); #1;
      clrb = 1'b0;
      bitq.delete();
      wordq.delete();
      pend = 1'b0;
      #1;
      chk("mid_rst_out", {sd_valid, sdr_out, word_done, din_ready}, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      clrb = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_ready", din_ready, 1);
      repeat (4) begin @(posedge clk); #1; chk("no_resume", sd_valid, 0); end
      send(4'b0101);
      wait_drain();

      // W=8 instance.
      chk("w8_ready", din_ready8, 1);
      din8 = 8'hA5; din_valid8 = 1'b1;
      @(posedge clk); #1;
      din_valid8 = 1'b0;
      chk("w8_lat", sd_valid8, 0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("w8_valid", sd_valid8, 1);
         chk("w8_bit", sdr_out8, bits8[i]);
         chk("w8_done", word_done8, (i == 7));
      end
      @(posedge clk); #1;
      chk("w8_idle", sd_valid8, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 Parameter W, default 4: word width in bits; legal range 2..16.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port clrb, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-004 Port din, input, W: parallel word to serialize.
REQ-005 Port din_valid, input, 1: din carries a word this cycle.
REQ-006 Port din_ready, output, 1: block can accept a word this cycle.
REQ-007 Port sdr_out, output, 1: serial data bit; drives the SDR input of the downstream right-shift register.
REQ-008 Port sd_valid, output, 1: sdr_out carries a live data bit this cycle.
REQ-009 Port word_done, output, 1: the last bit of the current word is on sdr_out this cycle.

Function
REQ-010 The block SHALL contain a W-bit holding register with a full flag, a W-bit shift register, a bit counter of ceil(log2 W) bits, and an FSM with states IDLE and SHIFT.
REQ-011 din_ready SHALL equal (not hold_full) AND clrb.
REQ-012 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; din is then written into the holding register and hold_full is set.
REQ-013 din SHALL be ignored on any edge where din_ready=0.
REQ-014 IDLE: if hold_full=1, the next edge SHALL move the holding register into the shift register, clear hold_full, set the counter to 0, and enter SHIFT.
REQ-015 SHIFT: sd_valid SHALL be 1 and sdr_out SHALL equal shift-register bit 0, so the word goes out LSB first.
REQ-016 SHIFT with counter < W-1: each edge SHALL shift the shift register right by one (MSB filled with 0) and increment the counter.
REQ-017 SHIFT with counter = W-1: word_done SHALL be 1 for that cycle.
REQ-018 On the edge that ends a word, if hold_full=1 the block SHALL reload the shift register from the holding register, clear hold_full, reset the counter to 0 and stay in SHIFT; this gives back-to-back words with no gap bit.
REQ-019 On the edge that ends a word, if hold_full=0 the block SHALL return to IDLE.
REQ-020 In IDLE, sd_valid, sdr_out and word_done SHALL all be 0.
REQ-021 Latency: for a word accepted at edge k with the block in IDLE, bit 0 SHALL appear on sdr_out after edge k+1, and bit W-1 after edge k+W.
REQ-022 Accept and transfer on the same edge are impossible: acceptance requires hold_full=0, and transfer requires hold_full=1.
REQ-023 A word accepted while a word is shifting SHALL wait in the holding register; no accepted word is ever dropped or overwritten.
REQ-024 Sustained throughput SHALL be one word per W cycles.
REQ-025 After a downstream right-shift register has seen W sd_valid edges for a word, its parallel output SHALL equal that word.

Reset
REQ-026 While clrb=0, independent of clk: state=IDLE, hold_full=0, holding register=0, shift register=0, counter=0.
REQ-027 While clrb=0: sdr_out=0, sd_valid=0, word_done=0, din_ready=0.
REQ-028 Reset asserted mid-word SHALL discard the shifting word and any held word; no partial word resumes.
REQ-029 On the first rising edge after clrb rises, din_ready SHALL be 1 and the block SHALL be in IDLE.

Verification
REQ-030 Reset: clrb=0 for 2 cycles with din_valid=1 -> all outputs 0 and no word accepted; din_ready=1 after release.
REQ-031 Single word (W=4): din=4'b1011 accepted at edge 1 -> sdr_out 1,1,0,1 with sd_valid=1 after edges 2..5; word_done only after edge 5; downstream register Q=4'b1011 after edge 5; IDLE after edge 6.
REQ-032 Back-to-back: 4'b0110 then 4'b1001 offered continuously -> 8 consecutive sd_valid cycles carrying 0,1,1,0,1,0,0,1; word_done exactly twice; din_ready low while a word is held.
REQ-033 Backpressure: din_valid held at 1 with a changing din while din_ready=0 -> only the values present on accepting edges are serialized.
REQ-034 Mid-word reset: clrb pulsed low after bit 2 of 4'b1111 with 4'b0001 held -> outputs 0 immediately; nothing resumes after release; the next accepted word serializes correctly.
REQ-035 Width check: W=8, din=8'hA5 -> LSB-first bits 1,0,1,0,0,1,0,1 and word_done on the 8th bit.
